// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming 2x2 / stride-2 max or average pooling over a
// raster-ordered feature map, one pixel per valid cycle, all channel lanes
// in parallel. One row of horizontal partial results is buffered on chip.
//
// Ports:
//   clk       rising-edge clock
//   irst      asynchronous active-high reset
//   in_valid  data_in accepted on this edge (no backpressure)
//   mode      0 = max, 1 = average; sampled with pixel (0,0) of a frame
//   data_in   channels x wordlength signed samples, lane 0 in the LSBs
//   data_out  pooled samples, held between pulses
//   out_valid one-cycle pulse per pooled pixel
//   out_last  with out_valid on the final pooled pixel of a frame
module pool2d_stream #(
    parameter int unsigned dataColNum = 28,
    parameter int unsigned dataRowNum = 28,
    parameter int unsigned wordlength = 16,
    parameter int unsigned channels   = 1
) (
    input  logic                           clk,
    input  logic                           irst,
    input  logic                           in_valid,
    input  logic                           mode,
    input  logic [channels*wordlength-1:0] data_in,
    output logic [channels*wordlength-1:0] data_out,
    output logic                           out_valid,
    output logic                           out_last
);

    localparam int unsigned W  = wordlength;
    localparam int unsigned DW = channels * wordlength;
    localparam int unsigned HC = dataColNum / 2;
    localparam int unsigned HR = dataRowNum / 2;
    localparam int unsigned CW = $clog2(dataColNum);
    localparam int unsigned RW = $clog2(dataRowNum);
    localparam int unsigned BW = (HC > 1) ? $clog2(HC) : 1;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic                 frame_mode;
    logic signed [W-1:0]  hlatch [channels];
    logic signed [W:0]    rowbuf [HC][channels];

    logic                 first_px_c;
    logic                 last_col_c;
    logic                 last_row_c;
    logic                 col_used_c;
    logic                 row_used_c;
    logic                 win_done_c;
    logic                 win_last_c;
    logic [BW-1:0]        buf_idx_c;
    logic signed [W-1:0]  samp_c [channels];
    logic signed [W:0]    h_c    [channels];
    logic signed [W:0]    bufv_c [channels];
    logic signed [W+1:0]  sum_c  [channels];
    logic [DW-1:0]        res_c;

    // Position decode; a trailing odd column/row is accepted but never pooled.
    always_comb begin
        first_px_c = (col == '0) && (row == '0);
        last_col_c = (col == CW'(dataColNum - 1));
        last_row_c = (row == RW'(dataRowNum - 1));
        col_used_c = ((dataColNum % 2) == 0) || !last_col_c;
        row_used_c = ((dataRowNum % 2) == 0) || !last_row_c;
        win_done_c = in_valid && row_used_c && row[0] && col[0];
        win_last_c = (row == RW'(2 * HR - 1)) && (col == CW'(2 * HC - 1));
        buf_idx_c  = BW'(col >> 1);
    end

    // Per-lane horizontal pair and vertical combine.
    always_comb begin
        res_c = '0;
        for (int k = 0; k < int'(channels); k++) begin
            samp_c[k] = data_in[k*W +: W];
            if (frame_mode) begin
                h_c[k] = {hlatch[k][W-1], hlatch[k]} + {samp_c[k][W-1], samp_c[k]};
            end else if (hlatch[k] > samp_c[k]) begin
                h_c[k] = {hlatch[k][W-1], hlatch[k]};
            end else begin
                h_c[k] = {samp_c[k][W-1], samp_c[k]};
            end
            bufv_c[k] = rowbuf[buf_idx_c][k];
            sum_c[k]  = {bufv_c[k][W], bufv_c[k]} + {h_c[k][W], h_c[k]};
            if (frame_mode) begin
                // floor(sum/4): dropping two LSBs of a two's-complement value
                res_c[k*W +: W] = sum_c[k][W+1:2];
            end else if (bufv_c[k] > h_c[k]) begin
                res_c[k*W +: W] = bufv_c[k][W-1:0];
            end else begin
                res_c[k*W +: W] = h_c[k][W-1:0];
            end
        end
    end

    // Counters, mode, horizontal latch and registered outputs.
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            col        <= '0;
            row        <= '0;
            frame_mode <= 1'b0;
            for (int k = 0; k < int'(channels); k++) begin
                hlatch[k] <= '0;
            end
            data_out   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (in_valid) begin
                if (first_px_c) begin
                    frame_mode <= mode;
                end
                if (last_col_c) begin
                    col <= '0;
                    row <= last_row_c ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (!col[0] && col_used_c) begin
                    for (int k = 0; k < int'(channels); k++) begin
                        hlatch[k] <= data_in[k*W +: W];
                    end
                end
                if (win_done_c) begin
                    data_out  <= res_c;
                    out_valid <= 1'b1;
                    out_last  <= win_last_c;
                end
            end
        end
    end

    // Row buffer: written on even rows, read on odd rows; no reset needed.
    always_ff @(posedge clk) begin
        if (in_valid && col[0] && !row[0] && row_used_c) begin
            for (int k = 0; k < int'(channels); k++) begin
                rowbuf[buf_idx_c][k] <= h_c[k];
            end
        end
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Testbench for pool2d_stream: a 4x4 single-lane instance driven with
// hand-computed directed frames, and a 28x28 three-lane instance checked
// against a per-window reference. Expected results are queued at issue time
// and popped by a monitor whenever out_valid is seen.
module tb_pool2d_stream;

    typedef struct {
        logic [47:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v4, m4, ov4, ol4;
    logic [15:0] d4, o4;
    logic        v28, m28, ov28, ol28;
    logic [47:0] d28, o28;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   pulses28 = 0;
    exp_t q4[$];
    exp_t q28[$];
    logic [15:0] hold4;
    logic [47:0] hold28;

    int   fb [3][28][28];
    int   mr, mc;
    logic fmode;

    logic [15:0] frame [16];
    logic [15:0] ex [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool2d_stream #(.dataColNum(4), .dataRowNum(4), .wordlength(16), .channels(1)) dut4 (
        .clk(clk), .irst(rst), .in_valid(v4), .mode(m4), .data_in(d4),
        .data_out(o4), .out_valid(ov4), .out_last(ol4)
    );

    pool2d_stream #(.dataColNum(28), .dataRowNum(28), .wordlength(16), .channels(3)) dut28 (
        .clk(clk), .irst(rst), .in_valid(v28), .mode(m28), .data_in(d28),
        .data_out(o28), .out_valid(ov28), .out_last(ol28)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold4  = '0;
                hold28 = '0;
            end
            if (ov4) begin
                if (q4.size() == 0) begin
                    chk("dut4 unexpected out_valid", 64'(o4), 64'hdead);
                end else begin
                    e = q4.pop_front();
                    chk("dut4 data_out", 64'(o4), 64'(e.data[15:0]));
                    chk("dut4 out_last", 64'(ol4), 64'(e.last));
                    chk("dut4 latency", 64'(cyc), 64'(e.cyc));
                    hold4 = e.data[15:0];
                end
            end else begin
                chk("dut4 out_last idle", 64'(ol4), 64'd0);
                chk("dut4 data_out hold", 64'(o4), 64'(hold4));
            end
            if (ov28) begin
                pulses28++;
                if (q28.size() == 0) begin
                    chk("dut28 unexpected out_valid", 64'(o28), 64'hdead);
                end else begin
                    e = q28.pop_front();
                    chk("dut28 data_out", 64'(o28), 64'(e.data));
                    chk("dut28 out_last", 64'(ol28), 64'(e.last));
                    chk("dut28 latency", 64'(cyc), 64'(e.cyc));
                    hold28 = e.data;
                end
            end else begin
                chk("dut28 out_last idle", 64'(ol28), 64'd0);
                chk("dut28 data_out hold", 64'(o28), 64'(hold28));
            end
        end
    endtask

    task automatic px4(input logic [15:0] d, input logic m, input bit has,
                       input logic [15:0] e, input bit last);
        exp_t x;
        v4 = 1'b1;
        m4 = m;
        d4 = d;
        if (has) begin
            x.data       = '0;
            x.data[15:0] = e;
            x.last       = last;
            x.cyc        = cyc + 1;
            q4.push_back(x);
        end
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    task automatic send_frame4(input logic [15:0] px [16], input logic m,
                               input logic [15:0] exv [4]);
        int j;
        bit has;
        j = 0;
        for (int i = 0; i < 16; i++) begin
            has = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            px4(px[i], m, has, has ? exv[j] : 16'h0, i == 15);
            if (has) j++;
        end
    endtask

    task automatic px28(input logic m);
        exp_t x;
        int   a, b, c, d, r;
        while ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            fb[k][mr][mc]      = k * 100 + mr * 28 + mc;
            d28[k*16 +: 16]    = 16'(fb[k][mr][mc]);
        end
        if (mr == 0 && mc == 0) fmode = m;
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            x.data = '0;
            for (int k = 0; k < 3; k++) begin
                a = fb[k][mr-1][mc-1];
                b = fb[k][mr-1][mc];
                c = fb[k][mr][mc-1];
                d = fb[k][mr][mc];
                if (fmode) begin
                    r = (a + b + c + d) >>> 2;
                end else begin
                    r = a;
                    if (b > r) r = b;
                    if (c > r) r = c;
                    if (d > r) r = d;
                end
                x.data[k*16 +: 16] = 16'(r);
            end
            x.last = (mr == 27) && (mc == 27);
            x.cyc  = cyc + 1;
            q28.push_back(x);
        end
        v28 = 1'b1;
        m28 = m;
        @(posedge clk);
        #1;
        v28 = 1'b0;
        if (mc == 27) begin
            mc = 0;
            mr = (mr == 27) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q4.size() != 0 || q28.size() != 0); i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        chk("dut4 queue drained", 64'(q4.size()), 64'd0);
        chk("dut28 queue drained", 64'(q28.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        v4 = 1'b0; m4 = 1'b0; d4 = '0;
        v28 = 1'b0; m28 = 1'b0; d28 = '0;
        mr = 0; mc = 0; fmode = 1'b0;
        hold4 = '0; hold28 = '0;
        fork
            monitor();
        join_none
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dut4 data_out", 64'(o4), 64'd0);
        chk("reset dut4 out_valid", 64'(ov4), 64'd0);
        chk("reset dut4 out_last", 64'(ol4), 64'd0);
        chk("reset dut28 data_out", 64'(o28), 64'd0);
        chk("reset dut28 out_valid", 64'(ov28), 64'd0);
        chk("reset dut28 out_last", 64'(ol28), 64'd0);
        rst = 1'b0;

        // 4x4 ramp, max then avg, back-to-back frames
        for (int i = 0; i < 16; i++) frame[i] = 16'(i);
        ex = '{16'd5, 16'd7, 16'd13, 16'd15};
        send_frame4(frame, 1'b0, ex);
        ex = '{16'd2, 16'd4, 16'd10, 16'd12};
        send_frame4(frame, 1'b1, ex);

        // average extremes: all max, all min, {-1,-1,-2,-2}, {-3,0,0,0}
        frame = '{16'h7fff, 16'h7fff, 16'h8000, 16'h8000,
                  16'h7fff, 16'h7fff, 16'h8000, 16'h8000,
                  16'hffff, 16'hffff, 16'hfffd, 16'h0000,
                  16'hfffe, 16'hfffe, 16'h0000, 16'h0000};
        ex = '{16'h7fff, 16'h8000, 16'hfffe, 16'hffff};
        send_frame4(frame, 1'b1, ex);

        // max extremes: {-32768,-1,-5,-32768}, {32767,0,0,0}, all min, {-2,-7,-3,-9}
        frame = '{16'h8000, 16'hffff, 16'h7fff, 16'h0000,
                  16'hfffb, 16'h8000, 16'h0000, 16'h0000,
                  16'h8000, 16'h8000, 16'hfffe, 16'hfff9,
                  16'h8000, 16'h8000, 16'hfffd, 16'hfff7};
        ex = '{16'hffff, 16'h7fff, 16'h8000, 16'hfffe};
        send_frame4(frame, 1'b0, ex);
        drain();

        // 28x28x3 with gaps: mode raised at row 10 stays max, next frame avg
        for (int i = 0; i < 784; i++) px28(mr >= 10 ? 1'b1 : 1'b0);
        drain();
        chk("dut28 pulses frame A", 64'(pulses28), 64'd196);
        for (int i = 0; i < 784; i++) px28(1'b1);
        drain();
        chk("dut28 pulses frame B", 64'(pulses28), 64'd392);

        // reset after 37 pixels (two frames plus 5 in avg), then fresh ramp
        for (int i = 0; i < 16; i++) frame[i] = 16'(i);
        ex = '{16'd5, 16'd7, 16'd13, 16'd15};
        send_frame4(frame, 1'b0, ex);
        send_frame4(frame, 1'b0, ex);
        for (int i = 0; i < 5; i++) px4(frame[i], 1'b1, 1'b0, 16'h0, 1'b0);
        chk("pre-reset dut4 data_out", 64'(o4), 64'd15);
        rst = 1'b1;
        #1;
        chk("mid-frame reset data_out", 64'(o4), 64'd0);
        chk("mid-frame reset out_valid", 64'(ov4), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mr = 0; mc = 0;
        send_frame4(frame, 1'b0, ex);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pool2d_stream.md
# pool2d_stream

Streaming 2x2/stride-2 pooling engine, the parametrised successor to the fixed 2x2 line-buffer plus max-pool pair. It accepts a raster-ordered feature map one pixel per valid cycle. All channel lanes arrive in parallel. It buffers one row of horizontal partial results internally and emits one pooled pixel per 2x2 window. Per-frame mode selects max or average. It sits between a conv layer output and the next layer input and needs no external line buffer.

## Interface
Parameters:
- dataColNum, 28, input columns per row (≥2)
- dataRowNum, 28, input rows per frame (≥2)
- wordlength, 16, signed bits per channel sample
- channels, 1, parallel channel lanes; lane 0 is in the LSBs

Ports:
- clk  in  1  single clock; all logic on rising edge
- irst  in  1  asynchronous, active-high reset
- in_valid  in  1  data_in is accepted on this edge; no backpressure
- mode  in  1  0 = max, 1 = average; sampled only with the first pixel of a frame
- data_in  in  channels*wordlength  signed samples, one per lane
- data_out  out  channels*wordlength  pooled samples, one per lane
- out_valid  out  1  one-cycle pulse per pooled pixel
- out_last  out  1  high with out_valid on the final pooled pixel of a frame

## Operation
- Counters col (0..dataColNum-1) and row (0..dataRowNum-1) advance only on accepted pixels. col wraps to 0 and row increments; both wrap to 0 after the last pixel of a frame.
- Gaps in in_valid are allowed anywhere. State holds across gaps.
- Per lane, horizontal pair stage:
  - At even col, latch the sample.
  - At odd col, form h = max(latch, sample) in max mode, or latch+sample (wordlength+1 bits, sign-extended) in avg mode.
- Even row: write h into row buffer entry col>>1. The buffer is dataColNum/2 entries × channels × (wordlength+1) bits.
- Odd row: combine h with buffer entry col>>1:
  - max mode: result = max(buf, h).
  - avg mode: s = buf + h (wordlength+2 bits); result = s >>> 2 (arithmetic shift, floor toward −∞). The result always fits wordlength.
- Odd dataColNum: the last column of each row is accepted and ignored. Odd dataRowNum: the last row is accepted and ignored, and produces no output.
- Outputs per frame: (dataColNum/2)·(dataRowNum/2) using floor division. Default 196.
- Mode register frame_mode loads from mode when the accepted pixel has row=0, col=0. Mode changes mid-frame have no effect until the next frame.
- No arithmetic wraps. Max comparison is signed.

## Timing
- Reset (asynchronous assert, held while irst=1):
  - data_out=0, out_valid=0, out_last=0.
  - col=0, row=0, frame_mode=0, horizontal latch cleared.
  - Row buffer contents don't-care. They are always rewritten before being read.
- Latency: the pixel at (odd row, odd col) accepted on edge k produces data_out/out_valid/out_last registered on edge k. They are visible the cycle after the input and high for exactly one cycle, unless another window completes on the next accepted pixel. Back-to-back completion is impossible at stride 2, so out_valid is never high two consecutive cycles.
- data_out holds its last value when out_valid=0.
- out_last asserts only with out_valid, on the window at row=2·(dataRowNum/2)−1, col=2·(dataColNum/2)−1.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0) and samples mode.
- Frame boundary: the next frame's first pixel may be accepted the edge after the last pixel. There are no idle cycles between frames.
- Throughput: 1 pixel/cycle sustained.

## Test plan
- Max, 4x4 frame (dataColNum=dataRowNum=4), channels=1, data = raster index 0..15, continuous valid → outputs 5, 7, 13, 15. out_last on the 4th only. Each out_valid follows input indices 5, 7, 13, 15 by 1 cycle.
- Avg, same 4x4 ramp → 2, 4, 10, 12 (floor of 2.5, 4.5, 10.5, 12.5). Window of all −1 with −2 → (−1−1−2−2)>>>2 = −2.
- Extremes, wordlength=16, avg, window of all 32767 → 32767; all −32768 → −32768. Max of {−32768, −1, −5, −32768} → −1.
- channels=3, default 28x28, lane k = k·100 + raster index, random in_valid gaps (50% duty) → exactly 196 pulses. Every lane matches the reference model; out_last only on pulse 196.
- mode toggled mid-frame (start max, switch to avg at row 10) → the whole frame is max. The next frame started with mode=1 is avg.
- irst pulsed after 37 pixels of a frame, then a fresh 4x4 ramp → outputs immediately zero during reset, then exactly 5, 7, 13, 15 with no stale window emitted.
